oc_recovery: RTL and testbench
==============================

Name: oc_recovery

Overview:
- Downstream consumer of the overcurrent latch. Gates the two motor-driver enables (A, B) whenever `oc` is high.
- After a cooldown, pulses the latch's clear input and re-enables drive. Counts consecutive trips; after MAX_RETRIES it enters a latched lockout that only an operator `clear_fault` releases.
- Sits between the overcurrent detector and the PWM/motor-driver enable pins.

Parameters:
- COOLDOWN, 32'd1000000, cycles spent disabled after a trip before the latch is cleared; must be ≥ 1.
- MAX_RETRIES, 3, automatic retries allowed; the (MAX_RETRIES+1)th trip locks out; range 0..14.
- STABLE, 32'd4000000, consecutive RUN cycles without a trip after which `retry_cnt` returns to 0; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising clk edge resets the block.
- oc  in  1  overcurrent latch output; level, 1 = tripped.
- en_req  in  2  requested motor enables {B,A} from control logic.
- clear_fault  in  1  operator acknowledge; level, sampled only in LOCKOUT.
- en_out  out  2  motor enables {B,A} to the drivers.
- oc_clear  out  1  to the latch's active-high reset; single-cycle pulse.
- fault  out  1  1 while in LOCKOUT.
- retry_cnt  out  4  trips since the last stable period or fault clear.
- state  out  3  current FSM state, for debug/LEDs.

Behaviour:
- States: RUN=0, COOL=1, CLEAR=2, SETTLE=3, LOCKOUT=4. Encoding is fixed.
- Reset (reset=0 at edge): state←CLEAR, retry_cnt←0, timer←0, fault←0, internal enable register←0. While reset=0, en_out=0 and oc_clear=0. First cycle after reset releases is CLEAR, so the latch is always cleared at power-up.
- en_out = en_reg & {2{~oc}}. This combinational gate gives zero-latency cutoff on `oc` in every state.
- en_reg = en_req (registered) in RUN; 0 in all other states.
- RUN:
  - oc=1 at an edge: retry_cnt←retry_cnt+1 (saturates at 15).
  - If the new value > MAX_RETRIES → LOCKOUT. Otherwise → COOL with timer←COOLDOWN-1.
  - oc=0: stable timer increments. When it reaches STABLE-1, retry_cnt←0 and the timer restarts at 0. A trip clears the stable timer.
- COOL: timer decrements each cycle; `oc` is ignored. When timer==0 → CLEAR. Total time in COOL is exactly COOLDOWN cycles.
- CLEAR: oc_clear=1 for exactly this one cycle → SETTLE.
- SETTLE: `oc` is ignored for one cycle, covering the latch's one-cycle registered clear → RUN.
- LOCKOUT: fault=1, en_reg=0. clear_fault=1 at an edge: retry_cnt←0 → CLEAR. fault drops in the CLEAR cycle.
- oc_clear is 0 in every state except CLEAR. fault is 1 only in LOCKOUT.
- `oc` already high on entry to RUN (immediate re-trip) counts as a new trip on the first RUN edge.
- MAX_RETRIES=0: first trip goes straight to LOCKOUT.
- en_req changes outside RUN have no effect.
- reset=0 in any state, including mid-COOL or LOCKOUT, overrides all and produces the reset values.

Decomposition:
- Shared package/include `oc_pkg`: state encodings (RUN..LOCKOUT), state width 3, retry_cnt width 4. The status-LED decoder uses the same encodings.
- One sub-module: `cycle_timer`, a 32-bit down/up counter with synchronous load, clear, enable and a zero/terminal flag. oc_recovery instantiates it twice: cooldown and stable.

Test Plan (COOLDOWN=8, MAX_RETRIES=2, STABLE=16):
- Reset then release, en_req=2'b11, oc=0 → oc_clear=1 in cycle 1 only, SETTLE in cycle 2, en_out=2'b11 from the cycle after RUN is entered; fault=0, retry_cnt=0.
- In RUN, raise oc → en_out=0 in the same cycle; state=COOL for exactly 8 cycles; one oc_clear pulse; bench drops oc the cycle after the pulse; en_out returns to en_req; retry_cnt=1.
- Keep oc high through three successive trips → retry_cnt 1, 2, 3; on the 3rd trip state=LOCKOUT, fault=1, en_out=0, no further oc_clear pulses.
- In LOCKOUT, pulse clear_fault for 1 cycle → CLEAR (oc_clear=1, fault=0), then SETTLE, then RUN; retry_cnt=0.
- One trip and recovery, then 16 clean RUN cycles → retry_cnt goes 1→0 on cycle 16. A trip at cycle 10 instead gives retry_cnt=2.
- Assert reset=0 mid-COOL (timer=4) → next edge: state=CLEAR-pending, en_out=0, retry_cnt=0; after release, exactly one oc_clear pulse.

Source files
------------

// File: rtl/oc_recovery_pkg.sv
// ============================================================================
// oc_pkg : shared state encodings and widths for overcurrent recovery + LEDs
// Rev 1.0
// ============================================================================
`default_nettype none

package oc_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 3'd0,
    ST_COOL    = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : RETRY_W'(v + 1'b1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/oc_recovery_if.sv
// ============================================================================
// oc_recovery_if : latch/driver-side signal bundle of oc_recovery
// Rev 1.0
// ============================================================================
`default_nettype none

interface oc_recovery_if;
  import oc_pkg::*;

  logic               oc;
  logic [1:0]         en_req;
  logic               clear_fault;
  logic [1:0]         en_out;
  logic               oc_clear;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [STATE_W-1:0] state;

  modport master (
    output oc, en_req, clear_fault,
    input  en_out, oc_clear, fault, retry_cnt, state
  );

  modport slave (
    input  oc, en_req, clear_fault,
    output en_out, oc_clear, fault, retry_cnt, state
  );

endinterface

`default_nettype wire

// File: rtl/oc_recovery_cycle_timer.sv
// ============================================================================
// cycle_timer : up/down counter with load, clear, enable and terminal flag
// Rev 1.0
// ============================================================================
`default_nettype none

module cycle_timer #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         clr,
  input  wire logic         load,
  input  wire logic [W-1:0] load_val,
  input  wire logic         en,
  input  wire logic         up,
  input  wire logic [W-1:0] term_val,
  output logic              hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up ? W'(count_q + 1'b1) : W'(count_q - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == term_val);

endmodule

`default_nettype wire

// File: rtl/oc_recovery.sv
// ============================================================================
// oc_recovery : gates motor enables on overcurrent, retries after cooldown,
//               locks out after too many consecutive trips
// Rev 1.0
// ============================================================================
`default_nettype none

module oc_recovery #(
  parameter logic [31:0] COOLDOWN    = 32'd1000000,
  parameter int unsigned MAX_RETRIES = 3,
  parameter logic [31:0] STABLE      = 32'd4000000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  oc_recovery_if.slave  bus
);
  import oc_pkg::*;

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);

  state_e             state_q,  state_d;
  logic [RETRY_W-1:0] retry_q,  retry_d;
  logic [1:0]         en_reg_q, en_reg_d;

  logic cool_load, cool_en, cool_hit;
  logic stab_clr, stab_en, stab_hit;

  cycle_timer #(.W(32)) u_cool (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .load     (cool_load),
    .load_val (COOLDOWN - 32'd1),
    .en       (cool_en),
    .up       (1'b0),
    .term_val (32'd0),
    .hit      (cool_hit)
  );

  cycle_timer #(.W(32)) u_stable (
    .clk      (clk),
    .reset    (reset),
    .clr      (stab_clr),
    .load     (1'b0),
    .load_val (32'd0),
    .en       (stab_en),
    .up       (1'b1),
    .term_val (STABLE - 32'd1),
    .hit      (stab_hit)
  );

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    cool_load = 1'b0;
    cool_en   = 1'b0;
    stab_clr  = 1'b0;
    stab_en   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.oc) begin
          retry_d  = sat_inc(retry_q);
          stab_clr = 1'b1;
          if (retry_d > MAX_R) begin
            state_d = ST_LOCKOUT;
          end else begin
            state_d   = ST_COOL;
            cool_load = 1'b1;
          end
        end else if (stab_hit) begin
          retry_d  = '0;
          stab_clr = 1'b1;
        end else begin
          stab_en = 1'b1;
        end
      end
      ST_COOL: begin
        if (cool_hit) begin
          state_d = ST_CLEAR;
        end else begin
          cool_en = 1'b1;
        end
      end
      ST_CLEAR:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RUN;
      ST_LOCKOUT: begin
        if (bus.clear_fault) begin
          retry_d = '0;
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // The clean-run window only accumulates while actually running.
    if (state_q != ST_RUN) begin
      stab_clr = 1'b1;
    end

    en_reg_d = ((state_q == ST_RUN) && (state_d == ST_RUN)) ? bus.en_req : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_CLEAR;
      retry_q  <= '0;
      en_reg_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      en_reg_q <= en_reg_d;
    end
  end

  // Combinational gate on oc so cutoff never waits for a clock edge.
  assign bus.en_out    = reset ? (en_reg_q & {2{~bus.oc}}) : 2'b00;
  assign bus.oc_clear  = reset && (state_q == ST_CLEAR);
  assign bus.fault     = (state_q == ST_LOCKOUT);
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_oc_recovery.sv
// ============================================================================
// tb_oc_recovery : directed vector table plus multi-cycle trip/lockout sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_oc_recovery;

  localparam logic [2:0] S_RUN = 3'd0, S_COOL = 3'd1, S_CLEAR = 3'd2,
                         S_SETTLE = 3'd3, S_LOCK = 3'd4;

  typedef struct {
    logic       rst;
    logic       oc;
    logic [1:0] en_req;
    logic       cf;
    logic [2:0] st;
    logic [1:0] en;
    logic       clr;
    logic       flt;
    logic [3:0] rc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  oc_recovery_if bus();

  oc_recovery #(
    .COOLDOWN    (32'd8),
    .MAX_RETRIES (2),
    .STABLE      (32'd16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] s, input logic [1:0] e,
                       input logic c, input logic f, input logic [3:0] r);
    n_vec++;
    if (bus.state !== s || bus.en_out !== e || bus.oc_clear !== c ||
        bus.fault !== f || bus.retry_cnt !== r) begin
      n_bad++;
      $display("FAIL %s: got st=%0d en=%b clr=%b flt=%b rc=%0d, want st=%0d en=%b clr=%b flt=%b rc=%0d",
               nm, bus.state, bus.en_out, bus.oc_clear, bus.fault, bus.retry_cnt,
               s, e, c, f, r);
    end
  endtask

  // Eight COOL cycles then the CLEAR cycle; leaves the bench in CLEAR, unticked.
  task automatic cool_phase(input string nm, input logic [3:0] rc);
    for (int i = 0; i < 8; i++) begin
      check(nm, S_COOL, 2'b00, 1'b0, 1'b0, rc);
      tick();
    end
    check(nm, S_CLEAR, 2'b00, 1'b1, 1'b0, rc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];

    vecs.push_back(vec_t'{1'b0, 1'b0, 2'b11, 1'b0, S_CLEAR,  2'b00, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_CLEAR,  2'b00, 1'b1, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_SETTLE, 2'b00, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_RUN,    2'b00, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_RUN,    2'b11, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b01, 1'b0, S_RUN,    2'b11, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b01, 1'b0, S_RUN,    2'b01, 1'b0, 1'b0, 4'd0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b11, 1'b0, S_RUN,    2'b00, 1'b0, 1'b0, 4'd0});
    for (int i = 0; i < 4; i++)
      vecs.push_back(vec_t'{1'b1, 1'b1, 2'b10, 1'b0, S_COOL, 2'b00, 1'b0, 1'b0, 4'd1});
    for (int i = 0; i < 4; i++)
      vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_COOL, 2'b00, 1'b0, 1'b0, 4'd1});
    vecs.push_back(vec_t'{1'b1, 1'b1, 2'b11, 1'b0, S_CLEAR,  2'b00, 1'b1, 1'b0, 4'd1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_SETTLE, 2'b00, 1'b0, 1'b0, 4'd1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_RUN,    2'b00, 1'b0, 1'b0, 4'd1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 2'b11, 1'b0, S_RUN,    2'b11, 1'b0, 1'b0, 4'd1});

    reset = 1'b0;
    bus.oc = 1'b0;
    bus.en_req = 2'b11;
    bus.clear_fault = 1'b0;
    tick();
    tick();

    // Bring-up, first trip and recovery
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus.oc = vecs[i].oc;
      bus.en_req = vecs[i].en_req;
      bus.clear_fault = vecs[i].cf;
      #1;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].flt, vecs[i].rc);
      tick();
    end

    // Stable window: RUN cycles 3..16 keep the count, cycle 16 edge clears it
    for (int k = 3; k <= 16; k++) begin
      check($sformatf("stable_k%0d", k), S_RUN, 2'b11, 1'b0, 1'b0, 4'd1);
      tick();
    end
    check("stable_reset", S_RUN, 2'b11, 1'b0, 1'b0, 4'd0);

    // Trip, recover, trip again at RUN cycle 10 -> count 2, then lockout
    bus.oc = 1'b1;
    #1;
    check("trip_cut", S_RUN, 2'b00, 1'b0, 1'b0, 4'd0);
    tick();
    cool_phase("c_cool1", 4'd1);
    bus.oc = 1'b0;
    tick();
    check("c_settle1", S_SETTLE, 2'b00, 1'b0, 1'b0, 4'd1);
    tick();
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("c_run%0d", k), S_RUN, (k == 1) ? 2'b00 : 2'b11, 1'b0, 1'b0, 4'd1);
      tick();
    end
    bus.oc = 1'b1;
    #1;
    check("c_trip10", S_RUN, 2'b00, 1'b0, 1'b0, 4'd1);
    tick();
    cool_phase("c_cool2", 4'd2);
    tick();
    check("c_settle2", S_SETTLE, 2'b00, 1'b0, 1'b0, 4'd2);
    tick();
    check("c_retrip", S_RUN, 2'b00, 1'b0, 1'b0, 4'd2);
    tick();
    check("c_lock", S_LOCK, 2'b00, 1'b0, 1'b1, 4'd3);
    bus.oc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c_lock_hold", S_LOCK, 2'b00, 1'b0, 1'b1, 4'd3);
    end
    bus.clear_fault = 1'b1;
    #1;
    check("c_cf_seen", S_LOCK, 2'b00, 1'b0, 1'b1, 4'd3);
    tick();
    bus.clear_fault = 1'b0;
    #1;
    check("c_cf_clear", S_CLEAR, 2'b00, 1'b1, 1'b0, 4'd0);
    tick();
    check("c_cf_settle", S_SETTLE, 2'b00, 1'b0, 1'b0, 4'd0);
    tick();
    check("c_cf_run", S_RUN, 2'b00, 1'b0, 1'b0, 4'd0);
    tick();
    check("c_cf_run2", S_RUN, 2'b11, 1'b0, 1'b0, 4'd0);

    // oc held high through three successive trips
    bus.oc = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      #1;
      check($sformatf("d_trip%0d", t), S_RUN, 2'b00, 1'b0, 1'b0, 4'(t - 1));
      tick();
      if (t < 3) begin
        cool_phase($sformatf("d_cool%0d", t), 4'(t));
        tick();
        check($sformatf("d_settle%0d", t), S_SETTLE, 2'b00, 1'b0, 1'b0, 4'(t));
        tick();
      end
    end
    for (int i = 0; i < 10; i++) begin
      check("d_lock", S_LOCK, 2'b00, 1'b0, 1'b1, 4'd3);
      tick();
    end
    bus.oc = 1'b0;
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    #1;
    check("d_cf_clear", S_CLEAR, 2'b00, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    check("d_run", S_RUN, 2'b00, 1'b0, 1'b0, 4'd0);

    // Reset asserted mid-COOL with the cooldown timer at 4
    bus.oc = 1'b1;
    tick();
    bus.oc = 1'b0;
    tick();
    tick();
    tick();
    check("e_cool_t4", S_COOL, 2'b00, 1'b0, 1'b0, 4'd1);
    reset = 1'b0;
    tick();
    check("e_rst1", S_CLEAR, 2'b00, 1'b0, 1'b0, 4'd0);
    tick();
    check("e_rst2", S_CLEAR, 2'b00, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    #1;
    check("e_rel_clear", S_CLEAR, 2'b00, 1'b1, 1'b0, 4'd0);
    tick();
    check("e_settle", S_SETTLE, 2'b00, 1'b0, 1'b0, 4'd0);
    tick();
    check("e_run1", S_RUN, 2'b00, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("e_run", S_RUN, 2'b11, 1'b0, 1'b0, 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
